maxpool_img_server: RTL and testbench
=====================================

Name: maxpool_img_server

Overview:
- Memory-side responder for the maxpooling engine's read/write interface.
- Holds one INPUTSIZE x INPUTSIZE 8-bit image, loaded by a host streaming port.
- Runs the ready/busy handshake, then serves 4x4 window reads (eight 16-bit words, 1-cycle latency) and captures pooled-result writes into a result RAM that the host reads back.
- Replaces the behavioural image/answer arrays with synthesizable storage.

Parameters:
- COUNTERSIZE, 7, log2 of image side.
- INPUTSIZE, 128, image side in pixels; must equal 2**COUNTERSIZE.
- OUTPUTSIZE, INPUTSIZE/2, result side in pixels.

Ports:
- clk  in  1  single clock, all logic posedge.
- rst  in  1  asynchronous, active-low reset.
- ld_valid  in  1  host load word valid.
- ld_data  in  32  four raster-adjacent pixels; byte[31:24] is the leftmost pixel.
- ld_ready  out  1  server accepts a load word.
- start  in  1  1-cycle pulse; from DONE, restarts at LOAD.
- ready  out  1  to engine: image available.
- busy  in  1  from engine.
- ren  in  1  window read request.
- caddr_rd  in  2*COUNTERSIZE  top-left pixel address of window, row*INPUTSIZE+col.
- cdata_rd0..cdata_rd7  out  16 each  window words.
- wen  in  1  result write strobe.
- maddr_wr  in  2*(COUNTERSIZE-1)  result address.
- mdata_wr  in  8  result pixel.
- rb_addr  in  2*(COUNTERSIZE-1)  host result readback address.
- rb_data  out  8  result pixel at rb_addr, 1-cycle latency.
- done  out  1  engine finished.
- wr_count  out  2*(COUNTERSIZE-1)+1  result writes captured this run.
- proto_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset values: ld_ready=0, ready=0, cdata_rd0..7=0, rb_data=0, done=0, wr_count=0, proto_err=0. The FSM enters LOAD and the load counter clears. RAM contents are not cleared.
- FSM: LOAD -> HANDOFF -> SERVE -> DONE -> (start) -> LOAD.
- LOAD:
  - ld_ready=1.
  - Each ld_valid&&ld_ready writes ld_data to raster word index k and increments k.
  - After word INPUTSIZE*INPUTSIZE/4-1 is written, go to HANDOFF next cycle.
  - ld_valid outside LOAD is ignored.
- HANDOFF: ready=1. When busy is sampled 1, go to SERVE; ready drops in the same transition.
- SERVE:
  - ready=0.
  - busy sampled 0 -> DONE; done=1 from the next cycle. done holds until start or reset.
- Storage: 4 row banks. Bank b holds rows with row%4==b. Each bank word is 32 bits (4 pixels); word address = (row/4)*(INPUTSIZE/4)+col/4.
- Window read:
  - ren sampled 1 in SERVE with caddr_rd (row r, col c) -> on the next posedge:
    - cdata_rd0..3 = {P[r+i][c], P[r+i][c+1]} for i=0..3.
    - cdata_rd4..7 = {P[r+i][c+2], P[r+i][c+3]} for i=0..3.
  - Left pixel goes in the upper byte.
  - Outputs hold their values when ren=0. Back-to-back ren gives one window per cycle.
- Alignment: r%4 and c%4 must be 0. Unaligned address -> proto_err=1, and the window is served from the truncated (aligned-down) address.
- ren outside SERVE: cdata_rd outputs are forced to 0 and proto_err=1.
- Write capture:
  - wen in SERVE -> result[maddr_wr] = mdata_wr at that posedge; wr_count increments and saturates at OUTPUTSIZE*OUTPUTSIZE.
  - Duplicate address: last write wins and still counts.
  - wen outside SERVE: ignored, proto_err=1.
- Simultaneous wen and busy falling in the same cycle: the write is captured and the FSM still goes to DONE.
- Readback: rb_data = result[rb_addr] registered, available in every state.
- start outside DONE is ignored.
- On restart (start in DONE): load counter, wr_count, done and proto_err clear.
- Reset mid-run: immediate return to LOAD with all outputs at reset values. Loaded image data must be reloaded.

Decomposition:
- Package maxpool_pkg: COUNTERSIZE/INPUTSIZE/OUTPUTSIZE defaults, state enum (LOAD, HANDOFF, SERVE, DONE), pixel_t (8-bit), word_t (32-bit).
- Sub-module maxpool_bank_ram: 1 write port, 1 registered read port, 32-bit wide, INPUTSIZE*INPUTSIZE/16 deep. Instantiated 4x.
- The result RAM is an inline byte array.

Test Plan:
- Load ramp P[r][c]=(r*INPUTSIZE+c)&8'hFF; busy=1 at HANDOFF; ren with caddr=0 -> rd0=16'h0001, rd1=16'h8081, rd4=16'h0203, rd7=16'h8283 one cycle later.
- After loading, hold busy=0 for 5 cycles -> ready stays 1, state stays HANDOFF. Then busy=1 -> ready=0 the next cycle.
- Back-to-back ren at caddr=0,4,512 -> three consecutive windows, one per cycle, with correct values; ren=0 afterwards -> outputs hold.
- Write 4096 results mdata=maddr[7:0], then busy=0 -> done=1, wr_count=4096; rb_addr=4095 -> rb_data=8'hFF after 1 cycle.
- ren with caddr=2, and wen during HANDOFF -> proto_err=1; the wen leaves result unchanged and wr_count unchanged.
- Assert rst low mid-SERVE -> ready/done/wr_count=0, ld_ready=1 after release. start pulse in DONE -> LOAD with counters cleared.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and default geometry for the maxpool image server.
package maxpool_pkg;

  localparam int unsigned DEF_COUNTERSIZE = 7;
  localparam int unsigned DEF_INPUTSIZE   = 1 << DEF_COUNTERSIZE;
  localparam int unsigned DEF_OUTPUTSIZE  = DEF_INPUTSIZE / 2;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    HANDOFF = 2'd1,
    SERVE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef logic [7:0]  pixel_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/maxpool_bank_ram.sv
// One image row bank: single write port, registered read port with clear.
module maxpool_bank_ram
  import maxpool_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  word_t             wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output word_t             rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  word_t mem [DEPTH];
  word_t rd_data_d, rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its word while idle; clear wins over a read.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_clr)     rd_data_d = '0;
    else if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/maxpool_img_server.sv
// Memory-side responder for the maxpooling engine: image load, window reads,
// result capture and host readback.
module maxpool_img_server
  import maxpool_pkg::*;
#(
  parameter int unsigned COUNTERSIZE = DEF_COUNTERSIZE,
  parameter int unsigned INPUTSIZE   = DEF_INPUTSIZE,
  parameter int unsigned OUTPUTSIZE  = INPUTSIZE / 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ld_valid,
  input  logic [31:0]                    ld_data,
  output logic                           ld_ready,
  input  logic                           start,
  output logic                           ready,
  input  logic                           busy,
  input  logic                           ren,
  input  logic [2*COUNTERSIZE-1:0]       caddr_rd,
  output logic [15:0]                    cdata_rd0,
  output logic [15:0]                    cdata_rd1,
  output logic [15:0]                    cdata_rd2,
  output logic [15:0]                    cdata_rd3,
  output logic [15:0]                    cdata_rd4,
  output logic [15:0]                    cdata_rd5,
  output logic [15:0]                    cdata_rd6,
  output logic [15:0]                    cdata_rd7,
  input  logic                           wen,
  input  logic [2*(COUNTERSIZE-1)-1:0]   maddr_wr,
  input  logic [7:0]                     mdata_wr,
  input  logic [2*(COUNTERSIZE-1)-1:0]   rb_addr,
  output logic [7:0]                     rb_data,
  output logic                           done,
  output logic [2*(COUNTERSIZE-1):0]     wr_count,
  output logic                           proto_err
);

  localparam int unsigned AW        = 2 * COUNTERSIZE;
  localparam int unsigned KW        = 2 * COUNTERSIZE - 2;
  localparam int unsigned BW        = 2 * COUNTERSIZE - 4;
  localparam int unsigned CW        = 2 * (COUNTERSIZE - 1) + 1;
  localparam int unsigned RES_DEPTH = OUTPUTSIZE * OUTPUTSIZE;
  localparam logic [CW-1:0] WR_MAX  = CW'(RES_DEPTH);

  state_e          state_d, state_q;
  logic [KW-1:0]   k_d, k_q;
  logic [CW-1:0]   wr_count_d, wr_count_q;
  logic            proto_err_d, proto_err_q;
  logic            ld_ready_d, ld_ready_q;
  logic            ready_d, ready_q;
  logic            done_d, done_q;
  pixel_t          rb_data_d, rb_data_q;

  logic            ld_fire, in_serve, wen_ok, rd_en, rd_clr, unaligned, restart, viol;
  logic [1:0]      ld_bank;
  logic [BW-1:0]   ld_addr, rd_addr;
  word_t           bank_rd [4];
  pixel_t          res_mem [RES_DEPTH];

  assign in_serve  = (state_q == SERVE);
  assign ld_fire   = ld_valid && ld_ready_q && (state_q == LOAD);
  assign wen_ok    = wen && in_serve;
  assign rd_en     = ren && in_serve;
  assign rd_clr    = ren && !in_serve;
  assign unaligned = (|caddr_rd[COUNTERSIZE+1:COUNTERSIZE]) || (|caddr_rd[1:0]);
  assign viol      = (ren && (!in_serve || unaligned)) || (wen && !in_serve);

  // Load word k covers row k/(INPUTSIZE/4), columns 4*(k%(INPUTSIZE/4)) .. +3.
  assign ld_bank = k_q[COUNTERSIZE-1:COUNTERSIZE-2];
  assign ld_addr = {k_q[KW-1:COUNTERSIZE], k_q[COUNTERSIZE-3:0]};
  assign rd_addr = {caddr_rd[AW-1:COUNTERSIZE+2], caddr_rd[COUNTERSIZE-1:2]};

  for (genvar b = 0; b < 4; b++) begin : g_bank
    maxpool_bank_ram #(.ADDR_W(BW)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ld_fire && (ld_bank == 2'(b))),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_en   (rd_en),
      .rd_clr  (rd_clr),
      .rd_addr (rd_addr),
      .rd_data (bank_rd[b])
    );
  end

  // Next-state, counters and registered output decode.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wr_count_d  = wr_count_q;
    restart     = 1'b0;
    case (state_q)
      LOAD: begin
        if (ld_fire) begin
          k_d = k_q + KW'(1);
          if (k_q == '1) state_d = HANDOFF;
        end
      end
      HANDOFF: if (busy)  state_d = SERVE;
      SERVE:   if (!busy) state_d = DONE;
      DONE: begin
        if (start) begin
          state_d = LOAD;
          restart = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase

    if (wen_ok && (wr_count_q != WR_MAX)) wr_count_d = wr_count_q + CW'(1);
    if (restart) begin
      k_d        = '0;
      wr_count_d = '0;
    end
    proto_err_d = (restart ? 1'b0 : proto_err_q) | viol;

    ld_ready_d = (state_d == LOAD);
    ready_d    = (state_d == HANDOFF);
    done_d     = (state_d == DONE);
    rb_data_d  = res_mem[rb_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      k_q         <= '0;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      rb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
      ld_ready_q  <= ld_ready_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rb_data_q   <= rb_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wen_ok) res_mem[maddr_wr] <= mdata_wr;
  end

  assign ld_ready  = ld_ready_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign wr_count  = wr_count_q;
  assign proto_err = proto_err_q;
  assign rb_data   = rb_data_q;

  // Upper half of each bank word is the left pixel pair.
  assign cdata_rd0 = bank_rd[0][31:16];
  assign cdata_rd1 = bank_rd[1][31:16];
  assign cdata_rd2 = bank_rd[2][31:16];
  assign cdata_rd3 = bank_rd[3][31:16];
  assign cdata_rd4 = bank_rd[0][15:0];
  assign cdata_rd5 = bank_rd[1][15:0];
  assign cdata_rd6 = bank_rd[2][15:0];
  assign cdata_rd7 = bank_rd[3][15:0];

endmodule

// File: tb/tb_maxpool_img_server.sv
// Randomized self-checking bench for maxpool_img_server against a pixel-array model.
module tb_maxpool_img_server;

  localparam int IS  = 128;
  localparam int OS  = IS / 2;
  localparam int NW  = IS * IS / 4;
  localparam int NR  = OS * OS;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        start;
  logic        ready;
  logic        busy;
  logic        ren;
  logic [13:0] caddr_rd;
  logic [15:0] cdata_rd0, cdata_rd1, cdata_rd2, cdata_rd3;
  logic [15:0] cdata_rd4, cdata_rd5, cdata_rd6, cdata_rd7;
  logic        wen;
  logic [11:0] maddr_wr;
  logic [7:0]  mdata_wr;
  logic [11:0] rb_addr;
  logic [7:0]  rb_data;
  logic        done;
  logic [12:0] wr_count;
  logic        proto_err;

  maxpool_img_server dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .ready(ready), .busy(busy), .ren(ren), .caddr_rd(caddr_rd),
    .cdata_rd0(cdata_rd0), .cdata_rd1(cdata_rd1), .cdata_rd2(cdata_rd2), .cdata_rd3(cdata_rd3),
    .cdata_rd4(cdata_rd4), .cdata_rd5(cdata_rd5), .cdata_rd6(cdata_rd6), .cdata_rd7(cdata_rd7),
    .wen(wen), .maddr_wr(maddr_wr), .mdata_wr(mdata_wr), .rb_addr(rb_addr), .rb_data(rb_data),
    .done(done), .wr_count(wr_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  logic [15:0] cd [8];
  assign cd[0] = cdata_rd0;
  assign cd[1] = cdata_rd1;
  assign cd[2] = cdata_rd2;
  assign cd[3] = cdata_rd3;
  assign cd[4] = cdata_rd4;
  assign cd[5] = cdata_rd5;
  assign cd[6] = cdata_rd6;
  assign cd[7] = cdata_rd7;

  // Reference state: the image as pixels, the result array and the write count.
  logic [7:0] img   [IS][IS];
  logic [7:0] res_m [NR];
  int         wr_m;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_win(input int r, input int c, input int j);
    int rr;
    int cc;
    rr = r + (j % 4);
    cc = c + (j / 4) * 2;
    return {img[rr][cc], img[rr][cc+1]};
  endfunction

  task automatic check_win(input string tag, input int r, input int c);
    for (int j = 0; j < 8; j++) chk(tag, 32'(cd[j]), 32'(exp_win(r, c, j)));
  endtask

  task automatic check_zero_win(input string tag);
    for (int j = 0; j < 8; j++) chk(tag, 32'(cd[j]), 32'd0);
  endtask

  // Streams the image in raster word order with random bubbles; ends in HANDOFF.
  task automatic load_image(input bit rnd);
    int k;
    int guard;
    int row;
    int col;
    k = 0;
    guard = 0;
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++)
        img[r][c] = rnd ? 8'($urandom) : 8'(r * IS + c);
    while (k < NW && guard < 4 * NW) begin
      @(negedge clk);
      guard++;
      row = k / (IS / 4);
      col = (k % (IS / 4)) * 4;
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = {img[row][col], img[row][col+1], img[row][col+2], img[row][col+3]};
      if (ld_valid && ld_ready) k++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    chk("load_words", 32'(k), 32'(NW));
    chk("handoff_ready", 32'(ready), 32'd1);
    chk("handoff_ld_ready", 32'(ld_ready), 32'd0);
  endtask

  task automatic rand_aligned(output int r, output int c);
    r = 4 * $urandom_range(0, IS / 4 - 1);
    c = 4 * $urandom_range(0, IS / 4 - 1);
  endtask

  // Drives one result write per cycle; busy falls together with the last write.
  task automatic write_results(input int n, input bit rnd_addr);
    int a;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      a = rnd_addr ? int'($urandom_range(0, NR - 1)) : i;
      d = rnd_addr ? 8'($urandom) : 8'(a);
      wen = 1'b1;
      maddr_wr = 12'(a);
      mdata_wr = d;
      res_m[a] = d;
      if (wr_m < NR) wr_m++;
      if (i == n - 1) busy = 1'b0;
      @(negedge clk);
    end
    wen = 1'b0;
  endtask

  task automatic check_readback(input string tag, input int a);
    rb_addr = 12'(a);
    @(negedge clk);
    chk(tag, 32'(rb_data), 32'(res_m[a]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int qr[$];
    int qc[$];
    int r;
    int c;
    int lr;
    int lc;

    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; start = 1'b0; busy = 1'b0;
    ren = 1'b0; caddr_rd = '0; wen = 1'b0; maddr_wr = '0; mdata_wr = '0; rb_addr = '0;
    wr_m = 0;
    repeat (3) @(negedge clk);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_rb_data", 32'(rb_data), 32'd0);
    check_zero_win("rst_cdata");
    rst = 1'b1;
    @(negedge clk);
    chk("ld_ready_up", 32'(ld_ready), 32'd1);

    // Run 1: ramp image, fixed and random windows, full ordered result set.
    load_image(1'b0);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("handoff_hold", 32'(ready), 32'd1);
    end
    busy = 1'b1;
    @(negedge clk);
    chk("serve_ready_low", 32'(ready), 32'd0);
    chk("serve_done_low", 32'(done), 32'd0);

    qr = '{0, 0, 4};
    qc = '{0, 4, 0};
    for (int i = 0; i < 5; i++) begin
      rand_aligned(r, c);
      qr.push_back(r);
      qc.push_back(c);
    end
    ren = 1'b1;
    caddr_rd = 14'(qr[0] * IS + qc[0]);
    for (int i = 1; i < qr.size(); i++) begin
      @(negedge clk);
      check_win("win_b2b", qr[i-1], qc[i-1]);
      caddr_rd = 14'(qr[i] * IS + qc[i]);
    end
    @(negedge clk);
    ren = 1'b0;
    caddr_rd = '0;
    check_win("win_b2b_last", qr[qr.size()-1], qc[qc.size()-1]);
    @(negedge clk);
    check_win("win_hold", qr[qr.size()-1], qc[qc.size()-1]);

    write_results(NR, 1'b0);
    chk("run1_done", 32'(done), 32'd1);
    chk("run1_wr_count", 32'(wr_count), 32'(wr_m));
    chk("run1_proto_err", 32'(proto_err), 32'd0);
    check_readback("run1_rb_last", NR - 1);
    for (int i = 0; i < 4; i++) check_readback("run1_rb_rand", int'($urandom_range(0, NR - 1)));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_ld_ready", 32'(ld_ready), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_wr_count", 32'(wr_count), 32'd0);
    wr_m = 0;

    // Run 2: random image, protocol violations in HANDOFF, random windows and writes.
    load_image(1'b1);
    wen = 1'b1; maddr_wr = 12'd7; mdata_wr = 8'h55;
    ren = 1'b1; caddr_rd = '0; rb_addr = 12'd7;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    chk("handoff_wen_err", 32'(proto_err), 32'd1);
    chk("handoff_wen_count", 32'(wr_count), 32'd0);
    check_zero_win("handoff_ren_zero");
    @(negedge clk);
    chk("handoff_wen_ignored", 32'(rb_data), 32'(res_m[7]));
    busy = 1'b1;
    @(negedge clk);
    lr = -1;
    lc = -1;
    for (int i = 0; i < 24; i++) begin
      ld_valid = 1'b1;
      ld_data = $urandom;
      ren = ($urandom_range(0, 3) != 0);
      rand_aligned(r, c);
      caddr_rd = 14'(r * IS + c);
      if (ren) begin
        lr = r;
        lc = c;
      end
      @(negedge clk);
      if (lr >= 0) check_win("win_rand", lr, lc);
    end
    ren = 1'b0;
    ld_valid = 1'b0;
    write_results(NR + 10, 1'b1);
    chk("run2_done", 32'(done), 32'd1);
    chk("run2_wr_sat", 32'(wr_count), 32'(NR));
    chk("run2_proto_sticky", 32'(proto_err), 32'd1);
    check_readback("run2_rb_7", 7);
    for (int i = 0; i < 6; i++) check_readback("run2_rb_rand", int'($urandom_range(0, NR - 1)));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart2_proto_err", 32'(proto_err), 32'd0);
    chk("restart2_wr_count", 32'(wr_count), 32'd0);
    wr_m = 0;

    // Run 3: unaligned window, then reset in the middle of SERVE.
    load_image(1'b1);
    busy = 1'b1;
    @(negedge clk);
    chk("run3_ready_low", 32'(ready), 32'd0);
    chk("run3_proto_clear", 32'(proto_err), 32'd0);
    r = $urandom_range(0, IS - 1);
    c = 4 * $urandom_range(0, IS / 4 - 1) + $urandom_range(1, 3);
    ren = 1'b1;
    caddr_rd = 14'(r * IS + c);
    @(negedge clk);
    ren = 1'b0;
    check_win("win_unaligned", r & ~3, c & ~3);
    chk("unaligned_err", 32'(proto_err), 32'd1);
    wen = 1'b1; maddr_wr = 12'd3; mdata_wr = 8'hA5;
    @(negedge clk);
    wen = 1'b0;
    chk("run3_wr_count", 32'(wr_count), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_proto_err", 32'(proto_err), 32'd0);
    chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check_zero_win("midrst_cdata");
    @(negedge clk);
    busy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ld_ready_up", 32'(ld_ready), 32'd1);
    chk("midrst_ready_after", 32'(ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
